// File: rtl/sfp_sc_register_port_pkg.sv
// Shared types and constants for the SFP slow-control register port.
// Optional feature macro: SC_PARITY_EN. When it is defined, an even-parity
// bit follows the data field of every frame, in both directions.
package sfp_sc_register_port_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CHECK,
        WAIT_RD,
        TX
    } sc_state_t;

`ifdef SC_PARITY_EN
    localparam int unsigned SC_PAR_BITS = 1;
`else
    localparam int unsigned SC_PAR_BITS = 0;
`endif

    localparam int unsigned SC_FRAME_LEN    = 1 + 7 + 32 + SC_PAR_BITS;
    localparam logic [31:0] SC_TIMEOUT_DATA = 32'hDEAD_BEEF;
    localparam logic        SC_RW_READ      = 1'b1;

    // Serial frame length for a given address/data width.
    function automatic int unsigned sc_frame_len(input int unsigned aw, input int unsigned dw);
        return 1 + aw + dw + SC_PAR_BITS;
    endfunction

endpackage

// File: rtl/sfp_sc_register_port_if.sv
// Local register-bank access bus driven by the slow-control register port.
// master: wr_o/rd_o strobes, addr_o, wdata_o out; rdata_i, rack_i in.
// slave : the register bank side of the same signals.
interface sfp_sc_register_port_if #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 32
) ();

    logic              wr_o;
    logic              rd_o;
    logic [ADDR_W-1:0] addr_o;
    logic [DATA_W-1:0] wdata_o;
    logic [DATA_W-1:0] rdata_i;
    logic              rack_i;

    modport master (
        output wr_o, rd_o, addr_o, wdata_o,
        input  rdata_i, rack_i
    );

    modport slave (
        input  wr_o, rd_o, addr_o, wdata_o,
        output rdata_i, rack_i
    );

endinterface

// File: rtl/sfp_sc_register_port_serializer.sv
// sc_frame_serializer: shifts an N-bit response word out on the SC field,
// one bit per tx_valid_i, MSB first, as {1, bit}; then presents 2'b00 and
// pulses done_o when that idle symbol is consumed.
// Ports: clk, rst (async, active-high), load_i/word_i (start a response),
//        tx_valid_i (packer consume strobe), tx_sc_o (SC field out),
//        done_o (one-cycle, trailing 2'b00 consumed).
// The SC_PARITY_EN macro only changes N, which the parent supplies.
module sc_frame_serializer #(
    parameter int unsigned N = 40
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [N-1:0] word_i,
    input  logic         tx_valid_i,
    output logic [1:0]   tx_sc_o,
    output logic         done_o
);

    localparam int unsigned LW = $clog2(N + 1);

    logic [N-1:0]  sh_q, sh_d;
    logic [LW-1:0] left_q, left_d;
    logic          active_q, active_d;

    always_comb begin
        sh_d     = sh_q;
        left_d   = left_q;
        active_d = active_q;
        done_o   = 1'b0;
        if (load_i) begin
            sh_d     = word_i;
            left_d   = LW'(N);
            active_d = 1'b1;
        end else if (active_q && tx_valid_i) begin
            if (left_q != '0) begin
                sh_d   = {sh_q[N-2:0], 1'b0};
                left_d = left_q - LW'(1);
            end else begin
                active_d = 1'b0;
                done_o   = 1'b1;
            end
        end
    end

    // Current symbol is held until the packer consumes it.
    assign tx_sc_o = (left_q != '0) ? {1'b1, sh_q[N-1]} : 2'b00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q     <= '0;
            left_q   <= '0;
            active_q <= 1'b0;
        end else begin
            sh_q     <= sh_d;
            left_q   <= left_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/sfp_sc_register_port.sv
// sfp_sc_register_port: reassembles serial register-access frames from the
// SC field of received GBT frames, issues write/read strobes to the local
// register bank, and serialises read responses onto the outgoing SC field.
// Optional feature macro: SC_PARITY_EN (even parity after the data field).
// Ports: clk, rst (async, active-high); rx_valid_i/rx_sc_i (RX SC samples);
//        tx_valid_i/tx_sc_o (TX SC symbols); reg_bus (register bank master);
//        busy_o, frame_err_o (one-cycle pulse), err_cnt_o (saturating).
module sfp_sc_register_port
    import sfp_sc_register_port_pkg::*;
#(
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_TIMEOUT = 1024,
    parameter int unsigned ERR_CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx_valid_i,
    input  logic [1:0]              rx_sc_i,
    input  logic                    tx_valid_i,
    output logic [1:0]              tx_sc_o,
    sfp_sc_register_port_if.master  reg_bus,
    output logic                    busy_o,
    output logic                    frame_err_o,
    output logic [ERR_CNT_W-1:0]    err_cnt_o
);

    localparam int unsigned N     = sc_frame_len(ADDR_W, DATA_W);
    localparam int unsigned PAY_W = 1 + ADDR_W + DATA_W;
    localparam int unsigned CNT_W = $clog2(N + 2);
    localparam int unsigned TMR_W = $clog2(RD_TIMEOUT + 1);

    sc_state_t state_q, state_d;
    logic [N-1:0]         shreg_q, shreg_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic                 drop_q, drop_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic              frm_rw;
    logic [ADDR_W-1:0] frm_addr;
    logic [DATA_W-1:0] frm_data;
    logic              frm_ok;
    logic              busy;
    logic              wr, rd, chk_err, to_err, drop_err, load, tx_done;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;
    logic [DATA_W-1:0] rsp_data;
    logic [PAY_W-1:0]  resp_payload;
    logic [N-1:0]      resp_word;

    assign frm_rw   = shreg_q[N-1];
    assign frm_addr = shreg_q[N-2 -: ADDR_W];
    assign frm_data = shreg_q[N-2-ADDR_W -: DATA_W];

    assign resp_payload = {SC_RW_READ, addr_mux, rsp_data};

`ifdef SC_PARITY_EN
    assign frm_ok    = (cnt_q == CNT_W'(N)) && !(^shreg_q);
    assign resp_word = {resp_payload, ^resp_payload};
`else
    assign frm_ok    = (cnt_q == CNT_W'(N));
    assign resp_word = resp_payload;
`endif

    assign busy = (state_q == CHECK) || (state_q == WAIT_RD) || (state_q == TX);

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        tmr_d     = tmr_q;
        drop_d    = drop_q;
        wr        = 1'b0;
        rd        = 1'b0;
        chk_err   = 1'b0;
        to_err    = 1'b0;
        drop_err  = 1'b0;
        load      = 1'b0;
        addr_mux  = addr_q;
        wdata_mux = wdata_q;
        rsp_data  = reg_bus.rdata_i;

        // A frame starting while busy is swallowed up to its terminator,
        // even if the port goes idle before that terminator arrives.
        if (rx_valid_i) begin
            if (!rx_sc_i[1]) begin
                drop_d = 1'b0;
            end else if (!drop_q && busy) begin
                drop_d   = 1'b1;
                drop_err = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (rx_valid_i && rx_sc_i[1] && !drop_q) begin
                    shreg_d = {{(N-1){1'b0}}, rx_sc_i[0]};
                    cnt_d   = CNT_W'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (rx_valid_i) begin
                    if (rx_sc_i[1]) begin
                        shreg_d = {shreg_q[N-2:0], rx_sc_i[0]};
                        if (cnt_q != CNT_W'(N + 1)) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                state_d = IDLE;
                cnt_d   = '0;
                if (!frm_ok) begin
                    chk_err = 1'b1;
                end else if (frm_rw != SC_RW_READ) begin
                    wr        = 1'b1;
                    addr_mux  = frm_addr;
                    wdata_mux = frm_data;
                    addr_d    = frm_addr;
                    wdata_d   = frm_data;
                end else begin
                    rd       = 1'b1;
                    addr_mux = frm_addr;
                    addr_d   = frm_addr;
                    tmr_d    = TMR_W'(1);
                    if (reg_bus.rack_i) begin
                        load    = 1'b1;
                        state_d = TX;
                    end else begin
                        state_d = WAIT_RD;
                    end
                end
            end
            WAIT_RD: begin
                if (reg_bus.rack_i) begin
                    load    = 1'b1;
                    state_d = TX;
                end else if (tmr_q == TMR_W'(RD_TIMEOUT)) begin
                    to_err   = 1'b1;
                    rsp_data = DATA_W'(SC_TIMEOUT_DATA);
                    load     = 1'b1;
                    state_d  = TX;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            TX: begin
                if (tx_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Coincident error sources collapse into a single pulse and count.
        frame_err_o = chk_err || to_err || drop_err;
        err_cnt_d   = err_cnt_q;
        if (frame_err_o && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            tmr_q     <= '0;
            drop_q    <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            tmr_q     <= tmr_d;
            drop_q    <= drop_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    sc_frame_serializer #(.N(N)) u_ser (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .word_i     (resp_word),
        .tx_valid_i (tx_valid_i),
        .tx_sc_o    (tx_sc_o),
        .done_o     (tx_done)
    );

    assign reg_bus.wr_o    = wr;
    assign reg_bus.rd_o    = rd;
    assign reg_bus.addr_o  = addr_mux;
    assign reg_bus.wdata_o = wdata_mux;
    assign busy_o          = busy;
    assign err_cnt_o       = err_cnt_q;

endmodule

// File: tb/tb_sfp_sc_register_port.sv
// Scoreboard bench for sfp_sc_register_port: stimulus pushes expected
// strobes/responses into queues, a negedge monitor pops and compares.
module tb_sfp_sc_register_port;

    localparam int unsigned ADDR_W     = 7;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned RD_TIMEOUT = 1024;
    localparam int unsigned ERR_CNT_W  = 16;
`ifdef SC_PARITY_EN
    localparam int N = 41;
`else
    localparam int N = 40;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 rx_valid_i = 1'b0;
    logic [1:0]           rx_sc_i = 2'b00;
    logic                 tx_valid_i = 1'b0;
    logic [1:0]           tx_sc_o;
    logic                 busy_o;
    logic                 frame_err_o;
    logic [ERR_CNT_W-1:0] err_cnt_o;

    sfp_sc_register_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sfp_sc_register_port #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RD_TIMEOUT (RD_TIMEOUT),
        .ERR_CNT_W  (ERR_CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_valid_i  (rx_valid_i),
        .rx_sc_i     (rx_sc_i),
        .tx_valid_i  (tx_valid_i),
        .tx_sc_o     (tx_sc_o),
        .reg_bus     (bus),
        .busy_o      (busy_o),
        .frame_err_o (frame_err_o),
        .err_cnt_o   (err_cnt_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [6:0]  addr;
        logic [31:0] data;
        int          cyc;
    } strobe_exp_t;

    strobe_exp_t wr_q[$];
    strobe_exp_t rd_q[$];
    logic [63:0] resp_q[$];

    int          exp_err = 0;
    int          err_seen = 0;
    int          last_rd_cyc = 0;
    int          last_err_cyc = 0;
    int          ack_delay = -1;
    logic [31:0] ack_data = '0;
    logic [63:0] tx_bits = '0;
    int          tx_n = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Frame as the wire carries it, MSB first, right-aligned.
    function automatic logic [63:0] mk_frame(input logic rw, input logic [6:0] a, input logic [31:0] d);
        logic [39:0] p;
        p = {rw, a, d};
`ifdef SC_PARITY_EN
        return {23'b0, p, ^p};
`else
        return {24'b0, p};
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard.
    initial begin
        strobe_exp_t e;
        logic [63:0] w;
        forever begin
            @(negedge clk);
            if (rst) begin
                tx_n     = 0;
                tx_bits  = '0;
                err_seen = 0;
            end else begin
                if (bus.wr_o) begin
                    check("wr_expected", 64'(wr_q.size() != 0), 64'd1);
                    if (wr_q.size() != 0) begin
                        e = wr_q.pop_front();
                        check("wr_addr", 64'(bus.addr_o), 64'(e.addr));
                        check("wr_data", 64'(bus.wdata_o), 64'(e.data));
                        check("wr_latency", 64'(cyc), 64'(e.cyc));
                    end
                end
                if (bus.rd_o) begin
                    last_rd_cyc = cyc;
                    check("rd_expected", 64'(rd_q.size() != 0), 64'd1);
                    if (rd_q.size() != 0) begin
                        e = rd_q.pop_front();
                        check("rd_addr", 64'(bus.addr_o), 64'(e.addr));
                        check("rd_latency", 64'(cyc), 64'(e.cyc));
                    end
                end
                if (frame_err_o) begin
                    err_seen++;
                    last_err_cyc = cyc;
                end
                if (tx_valid_i) begin
                    if (tx_sc_o[1]) begin
                        tx_bits = {tx_bits[62:0], tx_sc_o[0]};
                        tx_n++;
                    end else if (tx_n > 0) begin
                        check("tx_expected", 64'(resp_q.size() != 0), 64'd1);
                        if (resp_q.size() != 0) begin
                            w = resp_q.pop_front();
                            check("tx_word", tx_bits, w);
                            check("tx_len", 64'(tx_n), 64'(N));
                        end
                        tx_n    = 0;
                        tx_bits = '0;
                    end
                end
            end
        end
    end

    // Register bank read responder.
    initial begin
        bus.rack_i  = 1'b0;
        bus.rdata_i = '0;
        forever begin
            @(negedge clk);
            if (!rst && bus.rd_o) begin
                if (ack_delay == 0) begin
                    tick();
                    bus.rack_i  = 1'b0;
                    bus.rdata_i = $urandom;
                end else if (ack_delay > 0) begin
                    repeat (ack_delay) @(posedge clk);
                    #1;
                    bus.rack_i  = 1'b1;
                    bus.rdata_i = ack_data;
                    tick();
                    bus.rack_i  = 1'b0;
                    bus.rdata_i = $urandom;
                end
            end
        end
    end

    // TX packer pacing.
    initial begin
        forever begin
            tick();
            tx_valid_i = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic send(input logic [63:0] bits, input int n, input int stop_after, output int term_cyc);
        term_cyc = -1;
        for (int i = n - 1; i >= 0; i--) begin
            if (stop_after >= 0 && (n - 1 - i) == stop_after) begin
                tick();
                rx_valid_i = 1'b0;
                return;
            end
            repeat ($urandom_range(0, 2)) begin
                tick();
                rx_valid_i = 1'b0;
                rx_sc_i    = 2'($urandom);
            end
            tick();
            rx_valid_i = 1'b1;
            rx_sc_i    = {1'b1, bits[i]};
        end
        repeat ($urandom_range(0, 2)) begin
            tick();
            rx_valid_i = 1'b0;
            rx_sc_i    = 2'($urandom);
        end
        tick();
        rx_valid_i = 1'b1;
        rx_sc_i    = {1'b0, 1'($urandom)};
        term_cyc   = cyc;
        tick();
        rx_valid_i = 1'b0;
        rx_sc_i    = 2'b00;
    endtask

    task automatic do_write(input logic [6:0] a, input logic [31:0] d);
        int t;
        send(mk_frame(1'b0, a, d), N, -1, t);
        wr_q.push_back('{a, d, t + 1});
        repeat (3) tick();
        check("busy_after_wr", 64'(busy_o), 64'd0);
    endtask

    task automatic issue_read(input logic [6:0] a, input int delay, input logic [31:0] d);
        int t;
        logic [31:0] junk;
        junk      = $urandom;
        ack_delay = delay;
        ack_data  = d;
        if (delay == 0) begin
            bus.rack_i  = 1'b1;
            bus.rdata_i = d;
        end
        send(mk_frame(1'b1, a, junk), N, -1, t);
        rd_q.push_back('{a, 32'h0, t + 1});
        resp_q.push_back(mk_frame(1'b1, a, (delay < 0) ? 32'hDEAD_BEEF : d));
    endtask

    task automatic wait_resp(input int budget);
        int k;
        k = 0;
        while (resp_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        check("resp_done", 64'(resp_q.size()), 64'd0);
        resp_q.delete();
        repeat (3) tick();
        check("busy_after_rd", 64'(busy_o), 64'd0);
    endtask

    task automatic wait_tx_bits(input int nb);
        int k;
        k = 0;
        while (tx_n < nb && k < 600) begin
            tick();
            k++;
        end
        check("tx_started", 64'(tx_n >= nb), 64'd1);
    endtask

    task automatic check_errs();
        check("err_cnt", 64'(err_cnt_o), 64'(exp_err));
        check("err_pulses", 64'(err_seen), 64'(exp_err));
    endtask

    task automatic do_bad(input int n);
        int t;
        logic [63:0] bits;
        bits = {$urandom, $urandom};
        send(bits, n, -1, t);
        exp_err++;
        repeat (3) tick();
        check_errs();
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, 64'({tx_sc_o, bus.wr_o, bus.rd_o, bus.addr_o, bus.wdata_o,
                         busy_o, frame_err_o, err_cnt_o}), 64'd0);
    endtask

    task automatic async_reset(input string name);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs(name);
        tick();
        tick();
        resp_q.delete();
        rst     = 1'b0;
        exp_err = 0;
        tick();
    endtask

    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_outputs");
        rst = 1'b0;
        tick();

        do_write(7'h15, 32'h1234_5678);
        issue_read(7'h03, 5, 32'hCAFE_0001);
        wait_resp(600);
        do_bad(N - 1);
        do_bad(N + 5);

        issue_read(7'h2A, -1, 32'h0);
        exp_err++;
        wait_resp(RD_TIMEOUT + 400);
        check("timeout_latency", 64'(last_err_cyc - last_rd_cyc), 64'(RD_TIMEOUT));
        check_errs();

        issue_read(7'h44, 0, 32'h0BAD_F00D);
        wait_resp(600);
        issue_read(7'h6B, 3, 32'h8765_4321);
        wait_tx_bits(3);
        send(mk_frame(1'b0, 7'h11, 32'h1111_2222), N, -1, t);
        exp_err++;
        wait_resp(600);
        check_errs();

        send(mk_frame(1'b0, 7'h55, 32'hAAAA_5555), N, 12, t);
        async_reset("reset_mid_shift");
        do_write(7'h7F, 32'hFFFF_0000);
        check_errs();

        issue_read(7'h0C, 1, 32'h1357_9BDF);
        wait_tx_bits(10);
        async_reset("reset_mid_tx");
        do_write(7'h22, 32'h0F0F_A5A5);
        check_errs();

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 2))
                0: do_write(7'($urandom), $urandom);
                1: begin
                    issue_read(7'($urandom), int'($urandom_range(0, 8)), $urandom);
                    wait_resp(600);
                end
                default: begin
                    if ($urandom_range(0, 1) == 0) do_bad(int'($urandom_range(1, N - 1)));
                    else do_bad(int'($urandom_range(N + 1, N + 8)));
                end
            endcase
        end
        check_errs();

        repeat (5) tick();
        check("pending_wr", 64'(wr_q.size()), 64'd0);
        check("pending_rd", 64'(rd_q.size()), 64'd0);
        check("pending_resp", 64'(resp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3000000;
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sfp_sc_register_port.md
Name: sfp_sc_register_port

Overview:
- Consumes the 2-bit SC field (sc_data_b2) of each received t_sfp_stream GBT frame.
- Reassembles serial register-access frames and issues single-cycle write/read strobes to the local register bank.
- Serialises read responses back onto the SC field of the outgoing t_sfp_stream.
- Sits directly downstream of the GBT RX frame unpacker and upstream of the TX frame packer, alongside the motor and memory data paths.

Parameters:
- ADDR_W, 7, register address width; address MSB of the serial frame is the R/W flag.
- DATA_W, 32, register data width.
- RD_TIMEOUT, 1024, clk cycles allowed between rd_o and rack_i.
- ERR_CNT_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  GBT frame clock
- rst  in  1  asynchronous, active-high reset
- rx_valid_i  in  1  one-cycle strobe, rx_sc_i holds a new frame sample
- rx_sc_i  in  2  sc_data_b2 of received t_sfp_stream; [1]=frame enable, [0]=data
- tx_valid_i  in  1  one-cycle strobe, TX packer consumes tx_sc_o
- tx_sc_o  out  2  sc_data_b2 for outgoing t_sfp_stream; [1]=frame, [0]=data
- wr_o  out  1  write strobe, one cycle
- rd_o  out  1  read strobe, one cycle
- addr_o  out  ADDR_W  register address
- wdata_o  out  DATA_W  write data
- rdata_i  in  DATA_W  read data, sampled with rack_i
- rack_i  in  1  read acknowledge
- busy_o  out  1  high in any state other than IDLE/SHIFT
- frame_err_o  out  1  one-cycle error pulse
- err_cnt_o  out  ERR_CNT_W  saturating error count

Behaviour:
- Reset (async, rst=1): all outputs 0; FSM goes to IDLE; shift register and bit counter cleared. Reset mid-frame or mid-TX aborts silently, with no strobe and no error.
- Frame format, MSB first: 1 R/W bit (1=read), ADDR_W address bits, DATA_W data bits. Total N = 1+ADDR_W+DATA_W = 40 bits; data bits are ignored for reads.
- Only samples with rx_valid_i=1 are considered.
- IDLE: sample with rx_sc_i[1]=1 shifts rx_sc_i[0] in, sets count=1, goes to SHIFT.
- SHIFT: each sample with [1]=1 shifts one bit; count saturates at N+1. A sample with [1]=0 goes to CHECK.
- CHECK, one cycle:
  - count!=N: frame_err_o pulse, back to IDLE.
  - Write: addr_o/wdata_o updated and wr_o=1 in this same cycle, back to IDLE.
  - Read: addr_o updated, rd_o=1, go to WAIT_RD.
- Write latency: strobe is 1 clk after the terminating rx_valid_i sample.
- WAIT_RD: on rack_i=1, latch rdata_i and go to TX. After RD_TIMEOUT cycles without rack_i, latch 32'hDEAD_BEEF, pulse frame_err_o, go to TX. A rack_i in the same cycle as rd_o is accepted.
- TX: one bit per tx_valid_i. tx_sc_o = {1, bit}, sending the N-bit response {R/W=1, addr, data} MSB first. Next tx_valid_i outputs 2'b00, then IDLE. tx_sc_o is held between strobes.
- Receiving while busy: an rx frame start (rx_sc_i[1]=1) seen in WAIT_RD or TX is dropped. frame_err_o pulses once per dropped frame, on its first sample.
- Error counter: increments on every frame_err_o, saturates at all-ones, is never cleared except by rst.
- Simultaneous events: a timeout and a dropped-frame error in the same cycle give a single pulse and +1 count.

Optional Feature:
- SC_PARITY_EN defined: one even-parity bit is appended after the data, so N=41. CHECK additionally requires correct parity, else frame_err_o and no strobe. The TX response also carries a parity bit.
- Undefined: N=40, no parity generated or checked.

Decomposition:
- Shared package: sc_state_t enum (IDLE, SHIFT, CHECK, WAIT_RD, TX), SC_FRAME_LEN constant (parity-dependent), SC_TIMEOUT_DATA = 32'hDEAD_BEEF, SC_RW_READ = 1'b1.
- One natural sub-module: sc_frame_serializer (TX shift register plus tx_valid_i pacing), instantiated once.

Test Plan:
- Write frame W=0, addr 7'h15, data 32'h1234_5678 -> wr_o single pulse, addr_o=15h, wdata_o=12345678h, 1 clk after the last sample; no error.
- Read addr 7'h03, rack_i 5 cycles after rd_o with rdata_i=32'hCAFE_0001 -> tx_sc_o carries 40 bits {1,03h,CAFE0001h} with [1]=1, then 2'b00; busy_o clears.
- 39-bit frame -> no strobe, frame_err_o pulse, err_cnt_o=1; a 45-bit frame likewise gives err_cnt_o=2.
- Read with rack_i never asserted -> after 1024 cycles frame_err_o pulses and the response data is DEAD_BEEFh.
- New frame during TX -> dropped, one error pulse, TX completes unaltered.
- rst asserted mid-SHIFT and mid-TX -> outputs 0 immediately; the next clean write frame works normally.
